// File: rtl/quadra_bist_pkg.sv
// quadra_bist_pkg: shared state type for the quadratic-unit self-test sequencer
package quadra_bist_pkg;
  typedef enum logic [2:0] {IDLE, SEND, GAP, DRAIN, FIN} bist_state_t;
endpackage

// File: rtl/quadra_bist_ram.sv
// quadra_bist_ram: simple dual-port RAM with one write port and one registered read port
module quadra_bist_ram #(
  parameter int W = 24,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/quadra_bist.sv
// quadra_bist: streams preloaded vectors to the quadratic unit and checks its responses
module quadra_bist import quadra_bist_pkg::*; #(
  parameter int X_W = 24,
  parameter int Y_W = 24,
  parameter int DEPTH = 256,
  parameter int GAP_W = 4,
  parameter int TIMEOUT = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [X_W-1:0]   cfg_x,
  input  logic [Y_W-1:0]   cfg_y_exp,
  input  logic [AW:0]      num_vec,
  input  logic [GAP_W-1:0] gap,
  input  logic [Y_W-1:0]   tol,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   x,
  output logic             x_dv,
  input  logic [Y_W-1:0]   y,
  input  logic             y_dv,
  output logic [AW:0]      err_cnt,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_vld,
  output logic             timeout,
  output logic             overrun
);
  localparam int TW = $clog2(TIMEOUT + 1);
  bist_state_t state, state_nxt;
  logic [AW:0] nv, rcnt;
  logic [AW-1:0] scnt, idx_q;
  logic [GAP_W-1:0] gap_q, gcnt;
  logic [Y_W-1:0] tol_q, y_q, ye_rd;
  logic [X_W-1:0] x_rd;
  logic [TW-1:0] tcnt;
  logic [Y_W:0] diff;
  logic start_ok, last_send, active, cmp_v, mism, timeout_hit;
  quadra_bist_ram #(.W(X_W), .DEPTH(DEPTH)) u_x_ram (
    .clk(clk), .we(cfg_we && !busy), .waddr(cfg_addr), .wdata(cfg_x), .raddr(scnt), .rdata(x_rd)
  );
  quadra_bist_ram #(.W(Y_W), .DEPTH(DEPTH)) u_y_ram (
    .clk(clk), .we(cfg_we && !busy), .waddr(cfg_addr), .wdata(cfg_y_exp), .raddr(rcnt[AW-1:0]), .rdata(ye_rd)
  );
  always_comb begin
    start_ok = start && num_vec != '0 && num_vec <= (AW+1)'(DEPTH);
    last_send = {1'b0, scnt} == nv - 1'b1;
    active = state != IDLE;
    timeout_hit = state == DRAIN && rcnt != nv && tcnt == TW'(TIMEOUT);
    diff = y_q >= ye_rd ? {1'b0, y_q} - {1'b0, ye_rd} : {1'b0, ye_rd} - {1'b0, y_q};
    mism = diff > {1'b0, tol_q};
    busy = state == SEND || state == GAP || state == DRAIN;
    done = state == FIN;
    x = x_dv ? x_rd : '0;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !start ? IDLE : start_ok ? SEND : FIN;
      SEND:    state_nxt = last_send ? DRAIN : gap_q != '0 ? GAP : SEND;
      GAP:     state_nxt = gcnt == gap_q ? SEND : GAP;
      DRAIN:   state_nxt = rcnt == nv || timeout_hit ? FIN : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x_dv <= 1'b0;
      nv <= '0;
      gap_q <= '0;
      tol_q <= '0;
      scnt <= '0;
      gcnt <= '0;
      rcnt <= '0;
      tcnt <= '0;
      cmp_v <= 1'b0;
      y_q <= '0;
      idx_q <= '0;
      err_cnt <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      x_dv <= state == SEND;
      if (state == IDLE && start) begin
        nv <= num_vec;
        gap_q <= gap;
        tol_q <= tol;
        scnt <= '0;
        rcnt <= '0;
        tcnt <= '0;
        cmp_v <= 1'b0;
        err_cnt <= '0;
        first_err_idx <= '0;
        first_err_vld <= 1'b0;
        timeout <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (state == SEND) scnt <= scnt + 1'b1;
        gcnt <= state == SEND ? GAP_W'(1) : state == GAP ? gcnt + 1'b1 : gcnt;
        cmp_v <= active && y_dv && rcnt < nv;
        y_q <= y;
        idx_q <= rcnt[AW-1:0];
        if (active && y_dv && rcnt < nv) rcnt <= rcnt + 1'b1;
        if (active && y_dv && rcnt >= nv) overrun <= 1'b1;
        tcnt <= y_dv ? '0 : state == DRAIN ? tcnt + 1'b1 : tcnt;
        if (timeout_hit) timeout <= 1'b1;
        if (cmp_v && mism) begin
          err_cnt <= err_cnt != '1 ? err_cnt + 1'b1 : err_cnt;
          first_err_vld <= 1'b1;
          first_err_idx <= first_err_vld ? first_err_idx : idx_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_quadra_bist.sv
// tb_quadra_bist: table-driven check of the self-test sequencer against a latency-5 stub unit
module tb_quadra_bist;
  localparam int X_W = 24, Y_W = 24, DEPTH = 256, GAP_W = 4, TIMEOUT = 64, AW = 8;
  typedef struct {
    int n; int gap; int tol; int m1; int d1; int m2; int d2; int drop; bit inj; int seed;
    int e_err; int e_idx; bit e_vld; bit e_to; bit e_ov; int e_done;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0, start = 1'b0, x_dv, y_dv, busy, done, first_err_vld, timeout, overrun;
  logic [AW-1:0] cfg_addr = '0, first_err_idx;
  logic [X_W-1:0] cfg_x = '0, x;
  logic [Y_W-1:0] cfg_y_exp = '0, tol = '0, y;
  logic [AW:0] num_vec = '0, err_cnt;
  logic [GAP_W-1:0] gap = '0;
  logic inj = 1'b0;
  logic [4:0] pv;
  logic [Y_W-1:0] py [5];
  int drop_idx = -1, sent, checks = 0, failures = 0;
  vec_t tab [7];
  always #5 clk = ~clk;
  quadra_bist #(.X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH), .GAP_W(GAP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y_exp(cfg_y_exp),
    .num_vec(num_vec), .gap(gap), .tol(tol), .start(start), .busy(busy), .done(done), .x(x), .x_dv(x_dv),
    .y(y), .y_dv(y_dv), .err_cnt(err_cnt), .first_err_idx(first_err_idx), .first_err_vld(first_err_vld),
    .timeout(timeout), .overrun(overrun)
  );
  function automatic logic [X_W-1:0] xval(input int s, input int i);
    return X_W'((s * 7919 + i * 40503 + 17) & 32'h7FFFFF);
  endfunction
  function automatic logic [Y_W-1:0] golden(input logic [X_W-1:0] xi);
    return Y_W'(xi + 24'h123);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      sent <= 0;
    end else begin
      pv <= {pv[3:0], x_dv && sent != drop_idx};
      py[0] <= golden(x);
      for (int i = 1; i < 5; i++) py[i] <= py[i-1];
      sent <= (start && !busy) ? 0 : x_dv ? sent + 1 : sent;
    end
  end
  assign y_dv = pv[4] | inj;
  assign y = py[4];
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run(input int k, input vec_t v);
    int pulses = 0, first = 0, last = 0, gap_bad = 0, x_bad = 0, busy_bad = 0, rsp = 0, done_c = 0;
    bit got = 0, arm = 0;
    logic [Y_W-1:0] ye;
    string t;
    t = $sformatf("v%0d", k);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      ye = golden(xval(v.seed, i));
      if (i == v.m1) ye = Y_W'(int'(ye) + v.d1);
      if (i == v.m2) ye = Y_W'(int'(ye) + v.d2);
      cfg_we = 1'b1; cfg_addr = AW'(i); cfg_x = xval(v.seed, i); cfg_y_exp = ye;
      num_vec = (AW+1)'(v.n); gap = GAP_W'(v.gap); tol = Y_W'(v.tol); drop_idx = v.drop;
      start = (i == v.n - 1);
    end
    if (v.n == 0) begin
      @(negedge clk);
      num_vec = '0; gap = '0; tol = '0; drop_idx = -1; start = 1'b1;
    end
    for (int c = 1; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin cfg_we = 1'b0; start = 1'b0; end
      if (c == 3 && v.n > 0) begin start = 1'b1; num_vec = '0; end
      if (c == 4) start = 1'b0;
      inj = 1'b0;
      if (arm) begin inj = 1'b1; arm = 0; end
      else if (y_dv) begin rsp++; if (v.inj && rsp == v.n) arm = 1; end
      if (x_dv) begin
        if (pulses == 0) first = c; else if (c - last != v.gap + 1) gap_bad++;
        if (x !== xval(v.seed, pulses)) x_bad++;
        last = c;
        pulses++;
      end
      if (done) begin got = 1; done_c = c; end
      else if (!busy && v.n > 0) busy_bad++;
    end
    start = 1'b0;
    inj = 1'b0;
    chk({t, "_done_seen"}, got, 1);
    chk({t, "_pulses"}, pulses, v.n);
    chk({t, "_done_time"}, v.n > 0 ? done_c - last : done_c, v.e_done);
    if (v.n > 0) begin
      chk({t, "_first_x_dv"}, first, 2);
      chk({t, "_spacing"}, gap_bad, 0);
      chk({t, "_x_data"}, x_bad, 0);
      chk({t, "_busy_low_early"}, busy_bad, 0);
    end
    chk({t, "_err_cnt"}, err_cnt, v.e_err);
    chk({t, "_first_err_idx"}, first_err_idx, v.e_idx);
    chk({t, "_first_err_vld"}, first_err_vld, v.e_vld);
    chk({t, "_timeout"}, timeout, v.e_to);
    chk({t, "_overrun"}, overrun, v.e_ov);
    @(negedge clk);
    chk({t, "_done_one_cycle"}, done, 0);
    chk({t, "_idle_after"}, busy, 0);
  endtask
  initial begin
    int pc, dn;
    tab[0] = '{8, 0, 0, -1, 0, -1, 0, -1, 0, 1, 0, 0, 0, 0, 0, 7};
    tab[1] = '{8, 0, 1, 3, 2, 6, 1, -1, 0, 2, 1, 3, 1, 0, 0, 7};
    tab[2] = '{4, 3, 0, -1, 0, -1, 0, -1, 0, 3, 0, 0, 0, 0, 0, 7};
    tab[3] = '{6, 0, 0, -1, 0, -1, 0, 4, 0, 4, 1, 4, 1, 1, 0, 71};
    tab[4] = '{0, 0, 0, -1, 0, -1, 0, -1, 0, 5, 0, 0, 0, 0, 0, 1};
    tab[5] = '{256, 0, 0, -1, 0, -1, 0, -1, 1, 6, 0, 0, 0, 0, 1, 7};
    tab[6] = '{5, 2, 10, 0, 11, 4, -11, -1, 0, 7, 2, 0, 1, 0, 0, 7};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x_dv", x_dv, 0);
    chk("rst_x", x, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_flags", {first_err_vld, timeout, overrun, first_err_idx}, 0);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) run(k, tab[k]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = AW'(i); cfg_x = xval(9, i); cfg_y_exp = golden(xval(9, i));
      num_vec = 9'd8; gap = '0; tol = '0; drop_idx = -1; start = (i == 7);
    end
    pc = 0;
    for (int c = 1; c < 50 && pc < 3; c++) begin
      @(negedge clk);
      if (c == 1) begin cfg_we = 1'b0; start = 1'b0; end
      if (x_dv) pc++;
    end
    chk("rst_mid_pulses", pc, 3);
    rst = 1'b1;
    #1;
    chk("rst_mid_x_dv", x_dv, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || x_dv) dn++;
    end
    chk("rst_mid_no_done", dn, 0);
    run(10, tab[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quadra_bist.md
Name: quadra_bist

Overview:
On-chip built-in self-test sequencer for the quadratic approximation unit; it is the synthesizable, parametrised successor of the file-driven stimulus/response bench.
- Stimulus vectors x and expected results y_exp are preloaded into internal RAMs.
- On start it streams num_vec vectors to quadra_top with a programmable inter-sample gap.
- It captures y in order, compares each against y_exp within a tolerance, and reports error count, first failing index, and timeout/overrun status.

Parameters:
X_W, 24, width of x (U1.23)
Y_W, 24, width of y and y_exp
DEPTH, 256, vector RAM depth (power of 2); AW = $clog2(DEPTH)
GAP_W, 4, width of inter-sample gap field
TIMEOUT, 64, cycles allowed after last x_dv with no y_dv before aborting

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_we  in  1  write strobe for vector RAMs (ignored while busy)
cfg_addr  in  AW  RAM write address
cfg_x  in  X_W  stimulus word
cfg_y_exp  in  Y_W  expected response word
num_vec  in  AW+1  vectors per run (1..DEPTH); sampled at start
gap  in  GAP_W  idle cycles between x_dv pulses; sampled at start
tol  in  Y_W  unsigned absolute tolerance; sampled at start
start  in  1  one-cycle run request
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
x  out  X_W  stimulus to DUT
x_dv  out  1  stimulus valid
y  in  Y_W  DUT response
y_dv  in  1  DUT response valid
err_cnt  out  AW+1  mismatches in last run (saturating)
first_err_idx  out  AW  index of first mismatch
first_err_vld  out  1  at least one mismatch this run
timeout  out  1  run aborted by response timeout
overrun  out  1  y_dv received after num_vec responses

Behaviour:
- Reset, asynchronous, active-high: state IDLE; busy, done, x_dv, err_cnt, first_err_idx, first_err_vld, timeout, overrun = 0; x = 0. RAM contents are not reset.
- The state machine has five states: IDLE, SEND, GAP, DRAIN, FIN.
- IDLE:
  - start with num_vec in 1..DEPTH latches num_vec, gap and tol, clears all status outputs, sets busy, and enters SEND.
  - start with num_vec = 0 or > DEPTH pulses done next cycle without running and leaves status cleared.
  - start while busy is ignored.
- SEND:
  - RAMs use synchronous read with 1-cycle latency. The first x_dv occurs 2 cycles after the start cycle.
  - x_dv is high exactly 1 cycle per vector, with x registered alongside it.
  - If gap = 0, x_dv is asserted back-to-back. Otherwise the block enters GAP for gap cycles between pulses.
  - After the num_vec-th pulse the block enters DRAIN.
- Response side runs in parallel from the first x_dv until FIN:
  - A response counter rcnt indexes y_exp in arrival order.
  - On each y_dv with rcnt < num_vec, the block computes |y - y_exp[rcnt]| as Y_W+1-bit unsigned and flags a mismatch if it is > tol.
  - On mismatch, err_cnt increments, saturating at 2^(AW+1)-1. The first mismatch sets first_err_vld and captures first_err_idx = rcnt.
  - y_dv with rcnt == num_vec sets the sticky overrun flag and does no compare.
- Expected-value read:
  - The y_exp RAM read is pipelined: the address rcnt is always presented, and the compare uses registered data.
  - The compare result lands 1 cycle after y_dv. err_cnt is therefore updated 1 cycle after the triggering y_dv.
- DRAIN:
  - A timeout counter resets on every y_dv.
  - When rcnt == num_vec, the block waits 1 cycle for the pipelined compare, then enters FIN.
  - If the counter reaches TIMEOUT, the block sets timeout and enters FIN.
- FIN: one-cycle done pulse, busy drops in the same cycle, then IDLE. Status outputs hold until the next accepted start.
- Simultaneous cfg_we and start in IDLE: the write completes and the run uses the new data.
- rst asserted mid-run aborts immediately: no done pulse, and x_dv drops asynchronously.

Decomposition:
- Shared quadra package (quadra.vh): x_t, y_t, dv_t (existing) plus a bist_state_t enum.
- Sub-module quadra_bist_ram: simple dual-port RAM (1 write port, 1 synchronous read port, parametrised width/depth), instantiated once for x and once for y_exp.

Test Plan:
- Run matching: load 8 vectors with y_exp equal to the golden y, gap = 0, tol = 0, DUT latency 5 → x_dv 8 consecutive cycles starting 2 after start; done; err_cnt = 0; first_err_vld = 0; timeout = overrun = 0.
- Mismatch: same run with y_exp[3] += 2 and y_exp[6] += 1, tol = 1 → err_cnt = 1, first_err_idx = 3, first_err_vld = 1.
- Gap mode: gap = 3, num_vec = 4 → x_dv pulses spaced 4 cycles apart; 4 pulses total; busy high until done.
- Timeout: stub DUT that drops vector 5 of 6, TIMEOUT = 64 → done about 64 cycles after the last y_dv; timeout = 1; err_cnt reflects 5 compares.
- Overrun/boundary: num_vec = DEPTH with an extra y_dv injected after all responses (injected before done is observed) → overrun = 1. num_vec = 0 → done 1 cycle after start with no x_dv.
- Reset mid-run: assert rst in SEND after 3 pulses → x_dv = 0 and busy = 0 immediately; no done; a subsequent start runs cleanly.
